// File: rtl/mem_bus_decoder_pkg.sv
// Memory-map constants, bus FSM state type and default decode windows shared
// by the RV32I data-port decoder and its address matcher.
package mem_bus_decoder_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  // Enum order is the slave index order used on s_sel/s_ready/s_rdata.
  typedef enum logic [1:0] {
    SRC_GPIO = 2'd0,
    SRC_UART = 2'd1,
    SRC_RAM  = 2'd2,
    SRC_ROM  = 2'd3
  } MEM_SOURCE_t;

  localparam int N_MEM_SRC = 4;

  localparam logic [MEM_ADDR_W-1:0] GPIO_BASE = 32'h1001_0020;
  localparam logic [MEM_ADDR_W-1:0] GPIO_MASK = 32'hFFFF_FFF0;
  localparam logic [MEM_ADDR_W-1:0] UART_BASE = 32'h1001_0100;
  localparam logic [MEM_ADDR_W-1:0] UART_MASK = 32'hFFFF_FFF0;
  localparam logic [MEM_ADDR_W-1:0] RAM_BASE  = 32'h1001_0000;
  localparam logic [MEM_ADDR_W-1:0] RAM_MASK  = 32'hFFFF_F000;
  localparam logic [MEM_ADDR_W-1:0] ROM_BASE  = 32'h0040_0000;
  localparam logic [MEM_ADDR_W-1:0] ROM_MASK  = 32'hFFC0_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RESP_OK  = 2'd2,
    RESP_ERR = 2'd3
  } bus_state_t;

  // Packed windows, index N-1 in the MSBs down to index 0 in the LSBs.
  localparam logic [N_MEM_SRC*MEM_ADDR_W-1:0] DEF_SLV_BASE =
    {ROM_BASE, RAM_BASE, UART_BASE, GPIO_BASE};
  localparam logic [N_MEM_SRC*MEM_ADDR_W-1:0] DEF_SLV_MASK =
    {ROM_MASK, RAM_MASK, UART_MASK, GPIO_MASK};

endpackage

// File: rtl/mem_addr_match.sv
// Combinational priority address decoder: the lowest-index window that
// matches (addr & mask) == base wins; no match raises miss.
module mem_addr_match
  import mem_bus_decoder_pkg::*;
#(
  parameter int                            ADDR_W   = MEM_ADDR_W,
  parameter int                            N_SLAVES = N_MEM_SRC,
  parameter logic [N_SLAVES*ADDR_W-1:0]    SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0]    SLV_MASK = DEF_SLV_MASK
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [N_SLAVES-1:0] hit,
  output logic                miss
);

  always_comb begin
    hit  = '0;
    miss = 1'b1;
    // miss doubles as "nothing matched yet", which gives lower indices priority.
    for (int i = 0; i < N_SLAVES; i++) begin
      if (miss && ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hit[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_bus_decoder.sv
// Single-master bus bridge for the core data port: decodes the address into
// one slave window, waits for that slave's ready with a timeout, and registers
// the returned read data. Unmapped or timed-out accesses complete with m_err.
//
// Handshake: the master holds m_req (and its address/data) until it sees a
// one-cycle m_ready or m_err pulse; the request is sampled only in IDLE. A
// slave sees s_sel/s_we only while ACCESS, and completes by raising its own
// s_ready bit; ready bits of non-selected slaves are ignored.
module mem_bus_decoder
  import mem_bus_decoder_pkg::*;
#(
  parameter int                            ADDR_W   = MEM_ADDR_W,
  parameter int                            DATA_W   = MEM_DATA_W,
  parameter int                            N_SLAVES = N_MEM_SRC,
  parameter logic [N_SLAVES*ADDR_W-1:0]    SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0]    SLV_MASK = DEF_SLV_MASK,
  parameter int                            TIMEOUT  = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m_req,
  input  logic                       m_we,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic [N_SLAVES-1:0]        s_sel,
  output logic                       s_we,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_ready,
  input  logic                       err_clr,
  output logic                       err_valid,
  output logic [ADDR_W-1:0]          err_addr,
  output logic [1:0]                 dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  bus_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_SLAVES-1:0] hit, sel_q;
  logic                miss;
  logic                we_q;
  logic                ready_sel;
  logic [DATA_W-1:0]   rdata_sel;

  mem_addr_match #(
    .ADDR_W   (ADDR_W),
    .N_SLAVES (N_SLAVES),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_match (
    .addr (m_addr),
    .hit  (hit),
    .miss (miss)
  );

  always_comb begin
    ready_sel = |(s_ready & sel_q);
    rdata_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) rdata_sel = rdata_sel | s_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    m_ready = 1'b0;
    m_err   = 1'b0;
    s_sel   = '0;
    s_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_req) state_d = miss ? RESP_ERR : ACCESS;
      end
      ACCESS: begin
        s_sel = sel_q;
        s_we  = we_q;
        if (ready_sel) begin
          state_d = RESP_OK;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = RESP_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP_OK: begin
        m_ready = 1'b1;
        state_d = IDLE;
      end
      RESP_ERR: begin
        m_err   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_addr    <= '0;
      s_wdata   <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      m_rdata   <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      if (state_q == IDLE && m_req) begin
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        we_q    <= m_we;
        sel_q   <= hit;
      end
      if (state_q == ACCESS && ready_sel) begin
        m_rdata <= we_q ? '0 : rdata_sel;
      end else if (state_d == RESP_ERR) begin
        m_rdata <= '0;
      end
      // A new error outranks a simultaneous clear; otherwise the first error is kept.
      if (state_q == RESP_ERR) begin
        if (!err_valid || err_clr) begin
          err_valid <= 1'b1;
          err_addr  <= s_addr;
        end
      end else if (err_clr) begin
        err_valid <= 1'b0;
        err_addr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Self-checking bench for mem_bus_decoder: directed and random accesses with
// a response scoreboard, latency and slave-side checks, error status and reset.
module tb_mem_bus_decoder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TB_TIMEOUT = 15;

  logic           clk;
  logic           rst_n;
  logic           m_req;
  logic           m_we;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wdata;
  logic [DW-1:0]  m_rdata;
  logic           m_ready;
  logic           m_err;
  logic [NS-1:0]  s_sel;
  logic           s_we;
  logic [AW-1:0]  s_addr;
  logic [DW-1:0]  s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]  s_ready;
  logic           err_clr;
  logic           err_valid;
  logic [AW-1:0]  err_addr;
  logic [1:0]     dbg_state;

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [DW:0] exp_q[$];  // {err, rdata}

  mem_bus_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .err_clr   (err_clr),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response scoreboard
  always @(negedge clk) begin
    if (rst_n && (m_ready || m_err)) begin
      tests_run++;
      if (m_ready && m_err) begin
        fail_cnt++;
        $display("FAIL resp_both: m_ready and m_err high together");
      end else if (exp_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL resp_unexpected: got err=%0b data=%h with nothing outstanding", m_err, m_rdata);
      end else begin
        logic [DW:0] exp;
        exp = exp_q.pop_front();
        if ({m_err, m_rdata} !== exp)
          begin
            fail_cnt++;
            $display("FAIL resp_data: got err=%0b data=%h, expected err=%0b data=%h",
                     m_err, m_rdata, exp[DW], exp[DW-1:0]);
          end
      end
    end
  end

  // Driver: one complete access. tgt < 0 means unmapped; waits > TB_TIMEOUT never readies.
  task automatic run_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input int tgt, input int waits, input int exp_lat,
                            input bit keep_req, input bit clr_at_resp);
    logic [NS-1:0] exp_sel;
    logic [DW-1:0] slv_data [NS];
    logic [DW-1:0] rd;
    bit            exp_err;
    bit            done;
    int            c;
    exp_sel = '0;
    if (tgt >= 0) exp_sel[tgt] = 1'b1;
    for (int i = 0; i < NS; i++) begin
      slv_data[i] = $urandom;
      s_rdata[i*DW +: DW] = slv_data[i];
    end
    exp_err = (tgt < 0) || (waits > TB_TIMEOUT);
    rd = '0;
    if (!exp_err && !we) rd = slv_data[tgt[1:0]];
    exp_q.push_back({exp_err, rd});
    @(negedge clk);
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
    for (int i = 0; i < NS; i++) s_ready[i] = (i == tgt) ? 1'b0 : 1'($urandom_range(0, 1));
    @(posedge clk);
    c = 0;
    done = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (m_ready || m_err) begin
        done = 1;
        tests_run++;
        if (c != exp_lat) begin
          fail_cnt++;
          $display("FAIL latency addr=%h: got %0d cycles, expected %0d", addr, c, exp_lat);
        end
        if (!keep_req) m_req = 1'b0;
        if (clr_at_resp) err_clr = 1'b1;
        s_ready = '0;
      end else begin
        tests_run++;
        if ({s_sel, s_we, s_addr, s_wdata} !== {exp_sel, we, addr, wdata}) begin
          fail_cnt++;
          $display("FAIL slave_side cyc=%0d: got sel=%b we=%b addr=%h wdata=%h, expected sel=%b we=%b addr=%h wdata=%h",
                   c, s_sel, s_we, s_addr, s_wdata, exp_sel, we, addr, wdata);
        end
        for (int i = 0; i < NS; i++)
          s_ready[i] = (i == tgt) ? 1'(c > waits) : 1'($urandom_range(0, 1));
        // Master-side changes while busy must not leak into the access.
        m_addr  = $urandom;
        m_wdata = $urandom;
      end
    end
    if (!done) begin
      tests_run++;
      fail_cnt++;
      $display("FAIL no_response addr=%h: got none in 40 cycles, expected one at %0d", addr, exp_lat);
      m_req = 1'b0;
      s_ready = '0;
    end
    if (clr_at_resp) begin
      @(negedge clk);
      err_clr = 1'b0;
    end
  endtask

  task automatic check_err(input string name, input logic exp_v, input logic [AW-1:0] exp_a);
    tests_run++;
    if ({err_valid, err_addr} !== {exp_v, exp_a}) begin
      fail_cnt++;
      $display("FAIL %s: got err_valid=%b err_addr=%h, expected %b %h", name, err_valid, err_addr, exp_v, exp_a);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_ready = '0; err_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata, err_valid, err_addr, dbg_state} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_state: got rdata=%h rdy=%b err=%b sel=%b we=%b addr=%h wdata=%h ev=%b ea=%h st=%0d, expected all 0",
               m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata, err_valid, err_addr, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_gpio_read;
    run_access(1'b0, 32'h1001_0024, 32'h0, 0, 0, 2, 0, 0);
  endtask

  task automatic test_ram_write;
    run_access(1'b1, 32'h1001_0040, 32'hDEAD_BEEF, 2, 3, 5, 0, 0);
    run_access(1'b0, 32'h0040_0010, 32'h0, 3, 1, 3, 0, 0);
  endtask

  task automatic test_unmapped;
    run_access(1'b0, 32'h2000_0000, 32'h0, -1, 0, 1, 0, 0);
    @(negedge clk);
    check_err("err_first", 1'b1, 32'h2000_0000);
    run_access(1'b1, 32'h3000_0000, 32'h1234_5678, -1, 0, 1, 0, 0);
    @(negedge clk);
    check_err("err_hold", 1'b1, 32'h2000_0000);
  endtask

  task automatic test_timeout;
    run_access(1'b0, 32'h1001_0104, 32'h0, 1, 99, 2 + TB_TIMEOUT, 0, 0);
    @(negedge clk);
    check_err("err_timeout_hold", 1'b1, 32'h2000_0000);
  endtask

  task automatic test_err_clr;
    run_access(1'b0, 32'h3000_0000, 32'h0, -1, 0, 1, 0, 1);
    check_err("err_clr_collide", 1'b1, 32'h3000_0000);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check_err("err_clr", 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back;
    run_access(1'b0, 32'h1001_002C, 32'h0, 0, 0, 2, 1, 0);
    run_access(1'b0, 32'h1001_0800, 32'h0, 2, 2, 4, 1, 0);
    run_access(1'b1, 32'h1001_0108, 32'hCAFE_F00D, 1, 1, 3, 0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      int tgt, w;
      logic [AW-1:0] a;
      tgt = $urandom_range(0, NS - 1);
      w   = $urandom_range(0, 5);
      case (tgt)
        0:       a = 32'h1001_0020 + AW'($urandom_range(0, 15));
        1:       a = 32'h1001_0100 + AW'($urandom_range(0, 15));
        2:       a = 32'h1001_0200 + AW'($urandom_range(0, 32'h1FF));
        default: a = 32'h0040_0000 + AW'($urandom_range(0, 32'h3F_FFFF));
      endcase
      run_access(1'($urandom_range(0, 1)), a, $urandom, tgt, w, 2 + w, 0, 0);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h1001_0010; m_wdata = 32'h5555_AAAA; s_ready = '0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata, err_valid, err_addr, dbg_state} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_mid: got rdata=%h rdy=%b err=%b sel=%b we=%b addr=%h wdata=%h ev=%b ea=%h st=%0d, expected all 0",
               m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata, err_valid, err_addr, dbg_state);
    end
    m_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_ready || m_err) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      fail_cnt++;
      $display("FAIL idle_after_reset: got %0d completion pulses, expected 0", seen);
    end
    run_access(1'b0, 32'h1001_0028, 32'h0, 0, 0, 2, 0, 0);
  endtask

  initial begin
    test_reset();
    test_gpio_read();
    test_ram_write();
    test_unmapped();
    test_timeout();
    test_err_clr();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
